// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern sequencer: widths, mode/state enums,
// the accepted-command record and the per-step pattern update function.
// Pure package: no logic, no latency, no flow control.
package led_pkg;

  localparam int LED_W    = 8;
  localparam int RATE_W   = 4;
  localparam int BRIGHT_W = 4;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Command fields captured on a handshake and applied one cycle later.
  typedef struct packed {
    mode_e             mode;
    logic [LED_W-1:0]  pattern;
    logic [RATE_W-1:0] rate;
  } cmd_t;

  // Pattern value after one step. For BLINK, 'lit' says whether the base
  // pattern is currently on display, so the next step blanks it (or restores
  // it). STATIC never steps; returning the current value keeps the function
  // total.
  function automatic logic [LED_W-1:0] step_pattern(
    input mode_e            mode,
    input logic [LED_W-1:0] cur,
    input logic [LED_W-1:0] base,
    input logic             lit
  );
    logic [LED_W-1:0] nxt;
    nxt = cur;
    unique case (mode)
      MODE_STATIC: nxt = cur;
      MODE_BLINK:  nxt = lit ? '0 : base;
      MODE_CHASE:  nxt = {cur[LED_W-2:0], cur[LED_W-1]};
      MODE_COUNT:  nxt = cur + LED_W'(1);
      default:     nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/led_step_timer.sv
// Step prescaler: a TICK_DIV cycle base divider followed by a rate divider.
// Latency: step_o is combinational from the counter state; first step (rate+1)*TICK_DIV cycles after clear.
// Backpressure: none; pause_i freezes both counters, clear_i zeroes them and wins over everything.
//
// Ports:
//   clk_i, rst_i  clock and synchronous active-high reset
//   clear_i       zero both counters this edge (no step)
//   run_i         counters advance only while high
//   pause_i       hold both counters, suppress step
//   rate_i        step period is (rate_i+1) base ticks
//   step_o        high in the cycle whose rising edge completes a step period
module led_step_timer
  import led_pkg::*;
#(
  parameter int TICK_DIV = 1000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              run_i,
  input  logic              pause_i,
  input  logic [RATE_W-1:0] rate_i,
  output logic              step_o
);

  // A divide-by-1 still needs a one-bit counter that simply stays at zero.
  localparam int              DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0]  div_cnt_q,  div_cnt_d;
  logic [RATE_W-1:0] rate_cnt_q, rate_cnt_d;
  logic              tick;
  logic              rate_hit;

  assign tick     = (div_cnt_q == DIV_LAST);
  assign rate_hit = (rate_cnt_q == rate_i);

  always_comb begin
    div_cnt_d  = div_cnt_q;
    rate_cnt_d = rate_cnt_q;
    step_o     = 1'b0;
    if (clear_i) begin
      div_cnt_d  = '0;
      rate_cnt_d = '0;
    end else if (run_i && !pause_i) begin
      if (tick) begin
        div_cnt_d  = '0;
        rate_cnt_d = rate_hit ? '0 : rate_cnt_q + RATE_W'(1);
        step_o     = rate_hit;
      end else begin
        div_cnt_d  = div_cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt_q  <= '0;
      rate_cnt_q <= '0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      rate_cnt_q <= rate_cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_seq.sv
// Command-driven LED pattern generator: STATIC / BLINK / CHASE / COUNT patterns on an 8-bit LED byte.
// Latency: command accepted at edge N is visible on o_PS_LED after edge N+1; steps are registered (one-cycle o_step pulse).
// Backpressure: o_cmd_ready drops only for the single LOAD cycle and while reset is asserted.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_cmd_valid       command present (held stable until accepted)
//   o_cmd_ready       command can be accepted this cycle
//   i_cmd_mode        0 STATIC, 1 BLINK, 2 CHASE, 3 COUNT
//   i_cmd_pattern     initial/base pattern
//   i_cmd_rate        step period = (rate+1)*TICK_DIV cycles
//   i_cmd_bright      PWM duty (only used with LED_PATTERN_SEQ_PWM_EN)
//   i_pause           freeze the step engine
//   o_PS_LED          LED byte to the downstream output stage
//   o_step            one-cycle pulse on each pattern step
//   o_mode            currently active mode
//
// Build option: define LED_PATTERN_SEQ_PWM_EN to gate o_PS_LED with a
// 16-phase PWM whose duty is set by i_cmd_bright.
module led_pattern_seq
  import led_pkg::*;
#(
  parameter int TICK_DIV = 1000000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [1:0]          i_cmd_mode,
  input  logic [LED_W-1:0]    i_cmd_pattern,
  input  logic [RATE_W-1:0]   i_cmd_rate,
  input  logic [BRIGHT_W-1:0] i_cmd_bright,
  input  logic                i_pause,
  output logic [LED_W-1:0]    o_PS_LED,
  output logic                o_step,
  output logic [1:0]          o_mode
);

  state_e            state_q,   state_d;
  cmd_t              cmd_q,     cmd_d;      // latched at handshake
  mode_e             mode_q,    mode_d;     // applied in LOAD
  logic [RATE_W-1:0] rate_q,    rate_d;
  logic [LED_W-1:0]  pattern_q, pattern_d;
  logic [LED_W-1:0]  base_q,    base_d;
  logic              lit_q,     lit_d;      // BLINK: base currently shown
  logic              step_q,    step_d;

  logic cmd_ready;
  logic accept;
  logic timer_step;
  logic timer_clear;
  logic timer_run;

  // Ready is combinational on i_rst so that no handshake can complete on an
  // edge that is also resetting the block.
  assign cmd_ready = !i_rst && (state_q != ST_LOAD);
  assign accept    = i_cmd_valid && cmd_ready;

  // Counters restart from zero for every new command: held clear outside RUN
  // and on the accepting edge itself, so the LOAD->RUN edge leaves them at 0.
  assign timer_run   = (state_q == ST_RUN);
  assign timer_clear = !timer_run || accept;

  led_step_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_step_timer (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .clear_i (timer_clear),
    .run_i   (timer_run),
    .pause_i (i_pause),
    .rate_i  (rate_q),
    .step_o  (timer_step)
  );

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    mode_d    = mode_q;
    rate_d    = rate_q;
    pattern_d = pattern_q;
    base_d    = base_q;
    lit_d     = lit_q;
    step_d    = 1'b0;

    if (accept) begin
      cmd_d.mode    = mode_e'(i_cmd_mode);
      cmd_d.pattern = i_cmd_pattern;
      cmd_d.rate    = i_cmd_rate;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d   = ST_RUN;
        mode_d    = cmd_q.mode;
        rate_d    = cmd_q.rate;
        pattern_d = cmd_q.pattern;
        base_d    = cmd_q.pattern;
        lit_d     = 1'b1;
      end
      ST_RUN: begin
        // A new command aborts the sequence; a step due on the same edge is
        // dropped along with it.
        if (accept) begin
          state_d = ST_LOAD;
        end else if (timer_step && (mode_q != MODE_STATIC)) begin
          pattern_d = step_pattern(mode_q, pattern_q, base_q, lit_q);
          lit_d     = !lit_q;
          step_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      mode_q    <= MODE_STATIC;
      rate_q    <= '0;
      pattern_q <= '0;
      base_q    <= '0;
      lit_q     <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      mode_q    <= mode_d;
      rate_q    <= rate_d;
      pattern_q <= pattern_d;
      base_q    <= base_d;
      lit_q     <= lit_d;
      step_q    <= step_d;
    end
  end

`ifdef LED_PATTERN_SEQ_PWM_EN
  // Brightness follows the same latch-then-apply path as the other fields so
  // the new duty takes effect together with the new pattern.
  logic [BRIGHT_W-1:0] bright_cmd_q, bright_cmd_d;
  logic [BRIGHT_W-1:0] bright_q,     bright_d;
  logic [BRIGHT_W-1:0] pwm_cnt_q,    pwm_cnt_d;
  logic                pwm_on;

  always_comb begin
    bright_cmd_d = bright_cmd_q;
    bright_d     = bright_q;
    pwm_cnt_d    = pwm_cnt_q + BRIGHT_W'(1);
    if (accept)             bright_cmd_d = i_cmd_bright;
    if (state_q == ST_LOAD) bright_d     = bright_cmd_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bright_cmd_q <= '0;
      bright_q     <= '0;
      pwm_cnt_q    <= '0;
    end else begin
      bright_cmd_q <= bright_cmd_d;
      bright_q     <= bright_d;
      pwm_cnt_q    <= pwm_cnt_d;
    end
  end

  // "<=" rather than "<": duty is (bright+1)/16, so 15 is fully on and the
  // dimmest setting still lights for one phase in sixteen.
  assign pwm_on   = (pwm_cnt_q <= bright_q);
  assign o_PS_LED = pattern_q & {LED_W{pwm_on}};
`else
  logic unused_bright;
  assign unused_bright = ^i_cmd_bright;
  assign o_PS_LED      = pattern_q;
`endif

  assign o_cmd_ready = cmd_ready;
  assign o_step      = step_q;
  assign o_mode      = mode_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Scoreboard bench for led_pattern_seq with TICK_DIV = 4.
// Stimulus pushes expected observations (tagged with the edge count after
// which they must hold) into a queue; a negedge monitor pops and compares.
module tb_led_pattern_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_mode = 2'd0;
  logic [7:0] cmd_pattern = 8'h00;
  logic [3:0] cmd_rate = 4'd0;
  logic [3:0] cmd_bright = 4'd0;
  logic       pause = 1'b0;
  logic [7:0] ps_led;
  logic       step;
  logic [1:0] mode;

  led_pattern_seq #(.TICK_DIV(4)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_mode    (cmd_mode),
    .i_cmd_pattern (cmd_pattern),
    .i_cmd_rate    (cmd_rate),
    .i_cmd_bright  (cmd_bright),
    .i_pause       (pause),
    .o_PS_LED      (ps_led),
    .o_step        (step),
    .o_mode        (mode)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int         cyc;
    string      name;
    bit         c_led;
    logic [7:0] led;
    bit         c_rdy;
    logic       rdy;
    bit         c_step;
    logic       stp;
    bit         c_mode;
    logic [1:0] md;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rel_edge = 0;

  // -1 in any field means "don't check".
  function automatic void expect_at(input int cyc, input string name,
                                    input int led, input int rdy,
                                    input int stp, input int md);
    exp_t e;
    e.cyc    = cyc;
    e.name   = name;
    e.c_led  = (led >= 0);  e.led = 8'(led);
    e.c_rdy  = (rdy >= 0);  e.rdy = 1'(rdy);
    e.c_step = (stp >= 0);  e.stp = 1'(stp);
    e.c_mode = (md >= 0);   e.md  = 2'(md);
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= edge_n) begin
        e = sb[i];
        sb.delete(i);
        if (e.cyc < edge_n) begin
          n_tests++; n_fail++;
          $display("FAIL %s: check for edge %0d missed (now %0d)", e.name, e.cyc, edge_n);
        end else begin
          if (e.c_led) begin
            n_tests++;
            if (ps_led !== e.led) begin
              n_fail++;
              $display("FAIL %s @%0d: o_PS_LED=%h expected %h", e.name, edge_n, ps_led, e.led);
            end
          end
          if (e.c_rdy) begin
            n_tests++;
            if (cmd_ready !== e.rdy) begin
              n_fail++;
              $display("FAIL %s @%0d: o_cmd_ready=%b expected %b", e.name, edge_n, cmd_ready, e.rdy);
            end
          end
          if (e.c_step) begin
            n_tests++;
            if (step !== e.stp) begin
              n_fail++;
              $display("FAIL %s @%0d: o_step=%b expected %b", e.name, edge_n, step, e.stp);
            end
          end
          if (e.c_mode) begin
            n_tests++;
            if (mode !== e.md) begin
              n_fail++;
              $display("FAIL %s @%0d: o_mode=%0d expected %0d", e.name, edge_n, mode, e.md);
            end
          end
        end
      end
    end
  end

  task automatic wait_until(input int c);
    while (edge_n < c) begin
      @(posedge clk); #1;
    end
  endtask

  // Present a command and hold it until the handshake edge; n returns that
  // edge number. Called #1 after a rising edge.
  task automatic issue_cmd(input logic [1:0] m, input logic [7:0] p,
                           input logic [3:0] r, input logic [3:0] b,
                           output int n);
    bit done;
    done        = 1'b0;
    n           = -1;
    cmd_valid   = 1'b1;
    cmd_mode    = m;
    cmd_pattern = p;
    cmd_rate    = r;
    cmd_bright  = b;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        @(posedge clk); #1;
        n    = edge_n;
        done = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: o_cmd_ready=%b expected 1 within 20 cycles", cmd_ready);
      n = edge_n;
    end
  endtask

  initial begin : watchdog
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : stim
    int n, n1, k;

    // Power-on reset
    repeat (2) @(posedge clk); #1;
    expect_at(edge_n, "por_state", 8'h00, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0; rel_edge = edge_n;
    expect_at(edge_n, "por_release", 8'h00, 1, 0, 0);

    // CHASE 0x81, rate 0: period 4
    issue_cmd(2'd2, 8'h81, 4'd0, 4'd0, n);
    expect_at(n,      "chase_load",  -1,    0, 0, -1);
    expect_at(n + 1,  "chase_start", 8'h81, 1, 0, 2);
    expect_at(n + 4,  "chase_hold",  8'h81, -1, 0, -1);
    expect_at(n + 5,  "chase_s1",    8'h03, 1, 1, -1);
    expect_at(n + 6,  "chase_gap",   8'h03, -1, 0, -1);
    expect_at(n + 9,  "chase_s2",    8'h06, -1, 1, -1);
    expect_at(n + 13, "chase_s3",    8'h0C, -1, 1, -1);

    // Reset for 3 edges mid-CHASE
    wait_until(n + 14);
    k = edge_n;
    rst = 1'b1;
    expect_at(k,     "rst_rdy_low", 8'h0C, 0, -1, -1);
    expect_at(k + 1, "rst_led",     8'h00, 0, 0, 0);
    expect_at(k + 2, "rst_hold",    8'h00, 0, -1, -1);
    expect_at(k + 3, "rst_release", 8'h00, 1, 0, 0);
    wait_until(k + 3);
    rst = 1'b0; rel_edge = edge_n;

    // COUNT 0xFE, rate 1: period 8, wraps
    issue_cmd(2'd3, 8'hFE, 4'd1, 4'd0, n);
    expect_at(n + 1,  "cnt_start", 8'hFE, 1, 0, 3);
    expect_at(n + 8,  "cnt_hold",  8'hFE, -1, 0, -1);
    expect_at(n + 9,  "cnt_s1",    8'hFF, -1, 1, -1);
    expect_at(n + 16, "cnt_hold2", 8'hFF, -1, 0, -1);
    expect_at(n + 17, "cnt_wrap",  8'h00, -1, 1, -1);
    wait_until(n + 18);

    // BLINK 0xA5, rate 0, paused for 10 edges after the first step
    issue_cmd(2'd1, 8'hA5, 4'd0, 4'd0, n);
    expect_at(n + 1,  "blk_start",  8'hA5, 1, 0, 1);
    expect_at(n + 5,  "blk_s1",     8'h00, -1, 1, -1);
    expect_at(n + 9,  "blk_paused", 8'h00, -1, 0, -1);
    expect_at(n + 18, "blk_prestep", 8'h00, -1, 0, -1);
    expect_at(n + 19, "blk_s2",     8'hA5, -1, 1, -1);
    expect_at(n + 23, "blk_s3",     8'h00, -1, 1, -1);
    wait_until(n + 5);
    pause = 1'b1;
    wait_until(n + 15);
    pause = 1'b0;
    wait_until(n + 24);

    // Back-to-back commands, then a command landing on a step edge
    issue_cmd(2'd2, 8'h11, 4'd0, 4'd0, n1);
    expect_at(n1,      "b2b_ld1",  -1,    0, -1, -1);
    expect_at(n1 + 1,  "b2b_run1", 8'h11, 1, 0, 2);
    expect_at(n1 + 2,  "b2b_ld2",  8'h11, 0, 0, -1);
    expect_at(n1 + 3,  "b2b_run2", 8'h40, 1, 0, 3);
    expect_at(n1 + 6,  "coin_pre", 8'h40, -1, 0, -1);
    expect_at(n1 + 7,  "coin_acc", 8'h40, 0, 0, -1);
    expect_at(n1 + 8,  "coin_new", 8'h3C, 1, 0, 1);
    expect_at(n1 + 12, "coin_blk", 8'h00, -1, 1, -1);
    issue_cmd(2'd3, 8'h40, 4'd0, 4'd0, n);
    wait_until(n1 + 6);
    issue_cmd(2'd1, 8'h3C, 4'd0, 4'd0, n);
    wait_until(n1 + 13);

`ifdef LED_PATTERN_SEQ_PWM_EN
    // STATIC 0xFF at bright 3: on for pwm phases 0..3 of 16
    issue_cmd(2'd0, 8'hFF, 4'd0, 4'd3, n);
    for (int e = n + 1; e <= n + 16; e++)
      expect_at(e, "pwm_b3", (((e - rel_edge) % 16) <= 3) ? 8'hFF : 8'h00, -1, 0, 0);
    wait_until(n + 17);
    issue_cmd(2'd0, 8'hFF, 4'd0, 4'd15, n);
    for (int e = n + 1; e <= n + 16; e++)
      expect_at(e, "pwm_b15", 8'hFF, -1, 0, 0);
    wait_until(n + 17);
`endif

    repeat (3) @(posedge clk); #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++; n_fail++;
      $display("FAIL %s: check for edge %0d never reached (now %0d)", e.name, e.cyc, edge_n);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
